// File: rtl/ecc_scrub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ecc_scrub_ctrl
// Brief    : Post-SEC-DED scrub controller: single-bit write-back, double-bit
//            event counting with first-occurrence log and interrupt.
// Revision : 1.0  initial release
// ============================================================================
module ecc_scrub_ctrl #(
    parameter int AW    = 10,
    parameter int CW    = 39,
    parameter int SW    = 7,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             DEC_VLD,
    input  logic [AW-1:0]    DEC_ADDR,
    input  logic [CW-1:0]    DEC_DATA,
    input  logic [SW-1:0]    SYN,
    input  logic             ERR,
    input  logic             SGL,
    input  logic             DBL,
    input  logic             CLR,
    output logic             WB_VLD,
    input  logic             WB_RDY,
    output logic [AW-1:0]    WB_ADDR,
    output logic [CW-1:0]    WB_DATA,
    output logic [CNT_W-1:0] SGL_CNT,
    output logic [CNT_W-1:0] DBL_CNT,
    output logic [CNT_W-1:0] DROP_CNT,
    output logic             LOG_VLD,
    output logic [AW-1:0]    LOG_ADDR,
    output logic [SW-1:0]    LOG_SYN,
    output logic             IRQ
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        WB_REQ = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_load;
    logic               w_drop;
    logic               w_sgl_ev;
    logic               w_dbl_ev;
    logic               w_hs;
    logic               w_unused_err;

    logic [AW-1:0]      r_wb_addr;
    logic [CW-1:0]      r_wb_data;
    logic [CNT_W-1:0]   r_sgl_cnt;
    logic [CNT_W-1:0]   r_dbl_cnt;
    logic [CNT_W-1:0]   r_drop_cnt;
    logic               r_log_vld;
    logic [AW-1:0]      r_log_addr;
    logic [SW-1:0]      r_log_syn;

    // ERR alone (no SGL/DBL) is a clean event, so it never changes behaviour.
    assign w_unused_err = ERR;

    // DBL wins over the illegal SGL&DBL combination.
    assign w_dbl_ev = DEC_VLD & DBL;
    assign w_sgl_ev = DEC_VLD & SGL & ~DBL;
    assign w_hs     = (r_state == WB_REQ) & WB_RDY;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_sgl_ev) begin
                    w_state_nxt = WB_REQ;
                    w_load      = 1'b1;
                end
            end
            WB_REQ: begin
                if (w_hs) begin
                    if (w_sgl_ev) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_sgl_ev) begin
                    w_drop = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else if (w_load) begin
            r_wb_addr <= DEC_ADDR;
            r_wb_data <= DEC_DATA;
        end
    end

    // CLR overrides any same-cycle counter or log update.
    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            r_sgl_cnt  <= '0;
            r_dbl_cnt  <= '0;
            r_drop_cnt <= '0;
            r_log_vld  <= 1'b0;
            r_log_addr <= '0;
            r_log_syn  <= '0;
        end else begin
            if (w_sgl_ev && (r_sgl_cnt != {CNT_W{1'b1}})) begin
                r_sgl_cnt <= r_sgl_cnt + 1'b1;
            end
            if (w_dbl_ev && (r_dbl_cnt != {CNT_W{1'b1}})) begin
                r_dbl_cnt <= r_dbl_cnt + 1'b1;
            end
            if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
            if (w_dbl_ev && !r_log_vld) begin
                r_log_vld  <= 1'b1;
                r_log_addr <= DEC_ADDR;
                r_log_syn  <= SYN;
            end
        end
    end

    assign WB_VLD   = (r_state == WB_REQ);
    assign WB_ADDR  = r_wb_addr;
    assign WB_DATA  = r_wb_data;
    assign SGL_CNT  = r_sgl_cnt;
    assign DBL_CNT  = r_dbl_cnt;
    assign DROP_CNT = r_drop_cnt;
    assign LOG_VLD  = r_log_vld;
    assign LOG_ADDR = r_log_addr;
    assign LOG_SYN  = r_log_syn;
    assign IRQ      = r_log_vld;

endmodule
`default_nettype wire

// File: doc/ecc_scrub_ctrl.md
Name: ecc_scrub_ctrl

Overview:
- Sits directly downstream of the 39-bit SEC-DED decoder (32 data + 7 check bits).
- Consumes each decoded word's corrected codeword, syndrome and ERR/SGL/DBL flags.
- For single-bit errors, issues a scrub write-back of the corrected codeword through a valid/ready handshake.
- For double-bit errors, counts them, logs the first occurrence and raises an interrupt.

Parameters:
- AW, 10, memory address width of scrubbed words.
- CW, 39, codeword width (decoder FINOUT width).
- SW, 7, syndrome width.
- CNT_W, 8, width of each saturating event counter.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- DEC_VLD  in  1  decoder result valid this cycle; no backpressure, always accepted.
- DEC_ADDR  in  AW  address of the decoded word.
- DEC_DATA  in  CW  corrected codeword (decoder FINOUT).
- SYN  in  SW  decoder syndrome.
- ERR  in  1  nonzero syndrome.
- SGL  in  1  correctable single-bit error.
- DBL  in  1  uncorrectable double-bit error.
- CLR  in  1  clear counters and log.
- WB_VLD  out  1  write-back request valid.
- WB_RDY  in  1  memory accepts write-back.
- WB_ADDR  out  AW  write-back address.
- WB_DATA  out  CW  corrected codeword to write.
- SGL_CNT  out  CNT_W  single-bit event count.
- DBL_CNT  out  CNT_W  double-bit event count.
- DROP_CNT  out  CNT_W  single-bit events not written back because the WB slot was busy.
- LOG_VLD  out  1  first-DBL log holds data.
- LOG_ADDR  out  AW  address of first DBL.
- LOG_SYN  out  SW  syndrome of first DBL.
- IRQ  out  1  equals LOG_VLD.

Behaviour:
- Reset: all outputs 0; FSM in IDLE. Reset mid write-back drops the pending request; WB_VLD is 0 after the reset edge.
- Event classification, sampled only when DEC_VLD=1:
  - DBL=1 → uncorrectable. DBL takes precedence if SGL=DBL=1, which is an illegal combination.
  - Else SGL=1 → correctable.
  - Else clean: ERR=0, or ERR=1 with neither flag set. Clean events are ignored.
- Latency: event at edge N; counters, log and WB_VLD reflect it after edge N+1.
- FSM states:
  - IDLE: WB_VLD=0.
  - WB_REQ: WB_VLD=1.
- FSM transitions:
  - IDLE → WB_REQ on a correctable event; load WB_ADDR=DEC_ADDR, WB_DATA=DEC_DATA.
  - WB_REQ → IDLE when WB_VLD & WB_RDY and no new correctable event.
  - WB_REQ stays in WB_REQ when the handshake completes in the same cycle as a new correctable event; WB regs reload, giving back-to-back write-backs with no bubble.
  - WB_REQ with no handshake plus a new correctable event: the slot is kept unchanged and DROP_CNT increments.
- Handshake: WB_ADDR/WB_DATA are stable while WB_VLD=1 and WB_RDY=0. WB_VLD never drops without a transfer, except on RST.
- Counters:
  - SGL_CNT increments on every correctable event.
  - DBL_CNT increments on every uncorrectable event.
  - DROP_CNT increments as defined in the FSM transitions.
  - All three saturate at 2^CNT_W−1; no wrap.
- DBL log: on an uncorrectable event with LOG_VLD=0, capture LOG_ADDR and LOG_SYN and set LOG_VLD. Later DBLs update DBL_CNT only and never overwrite the log.
- CLR:
  - Zeroes SGL_CNT, DBL_CNT, DROP_CNT, LOG_VLD, LOG_ADDR and LOG_SYN next edge.
  - CLR wins over a same-cycle event's counter and log update.
  - That event's write-back is still processed.
  - CLR never affects WB_VLD, WB_ADDR or WB_DATA.
- DBL words are never written back.

Test Plan:
- Reset, then DEC_VLD with ERR=SGL=DBL=0 at addr 0x005 → all outputs stay 0, WB_VLD=0.
- SGL at addr 0x012, data 0x0E0000001, WB_RDY=1 → WB_VLD=1 with WB_ADDR=0x012 and WB_DATA=0x0E0000001 for exactly one cycle, one cycle after input; SGL_CNT=1.
- WB_RDY=0, SGL at 0x001 then SGL at 0x002 next cycle, then WB_RDY=1 → write-back of 0x001 only; DROP_CNT=1, SGL_CNT=2. Then SGL at 0x003 in the same cycle as the handshake → WB_VLD stays 1 with WB_ADDR=0x003.
- DBL at 0x030 with SYN=0x47, then DBL at 0x031 with SYN=0x13 → LOG_ADDR=0x030, LOG_SYN=0x47, IRQ=1, DBL_CNT=2. Then CLR → counters 0, IRQ=0.
- 300 consecutive SGL events with CNT_W=8 → SGL_CNT holds at 255.
- RST asserted while WB_VLD=1 and WB_RDY=0 → WB_VLD=0 after the next edge. CLR in the same cycle as SGL → SGL_CNT=0, WB_VLD=1.
